// File: rtl/riscv_imem_responder.sv
// Instruction-memory responder: the slave side of the fetch req/ack interface.
// A word-organised store answers accepted fetches with registered data and a
// one-cycle ack after WAIT_STATES extra cycles. A boot port fills the store
// while boot_en holds fetch off and aborts any in-flight fetch.

`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 32
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

module riscv_imem_responder #(
  parameter int                         INST_ADDR_WIDTH = `CFG_INST_ADDR_WIDTH,
  parameter int                         INST_DATA_WIDTH = `CFG_INST_DATA_WIDTH,
  parameter int                         MEM_DEPTH       = 1024,
  parameter int                         WAIT_STATES     = 0,
  parameter logic [INST_ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       imem_req,
  input  logic [INST_ADDR_WIDTH-1:0] imem_address,
  output logic [INST_DATA_WIDTH-1:0] imem_data_in,
  output logic                       imem_ack,
  output logic                       imem_err,
  input  logic                       boot_en,
  input  logic                       boot_we,
  input  logic [INST_ADDR_WIDTH-1:0] boot_addr,
  input  logic [INST_DATA_WIDTH-1:0] boot_wdata
);

  // MEM_DEPTH is a power of two, at least 2.
  localparam int                         IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0]                 WS    = 4'(WAIT_STATES);
  localparam logic [INST_DATA_WIDTH-1:0] NOP   = INST_DATA_WIDTH'(32'h0000_0013);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                 r_state;
  logic [3:0]                 r_cnt;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_in_range;
  logic                       r_ack;
  logic                       r_err;
  logic [INST_DATA_WIDTH-1:0] r_data;
  logic [INST_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [INST_ADDR_WIDTH-1:0] w_f_off;
  logic [INST_ADDR_WIDTH-1:0] w_b_off;
  logic                       w_f_in_range;
  logic                       w_b_in_range;
  logic [IDX_W-1:0]           w_f_idx;
  logic [IDX_W-1:0]           w_b_idx;
  logic                       w_accept;

  // Offsets from the base; anything at or past BASE+4*DEPTH has high bits set,
  // and addresses below the base are caught by the explicit compare (the
  // subtraction would wrap there). Byte-lane bits [1:0] are dropped.
  assign w_f_off      = imem_address - BASE_ADDR;
  assign w_b_off      = boot_addr - BASE_ADDR;
  assign w_f_in_range = (imem_address >= BASE_ADDR) && ((w_f_off >> (IDX_W + 2)) == '0);
  assign w_b_in_range = (boot_addr >= BASE_ADDR) && ((w_b_off >> (IDX_W + 2)) == '0);
  assign w_f_idx      = w_f_off[IDX_W+1:2];
  assign w_b_idx      = w_b_off[IDX_W+1:2];

  // A new fetch can be taken when idle or in the ack cycle of the previous one.
  assign w_accept = imem_req && !boot_en && ((r_state == S_IDLE) || (r_state == S_RESP));

  assign imem_ack     = r_ack;
  assign imem_err     = r_err;
  assign imem_data_in = r_data;

  // Request FSM: boot_en aborts whatever is in flight; address/range are
  // latched at acceptance so later address changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
    end else if (boot_en) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= S_RESP;
        end
        default: begin
          if (w_accept) begin
            r_idx      <= w_f_idx;
            r_in_range <= w_f_in_range;
            if (WS == 4'd0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WS;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Response register: the store is read on the RESP cycle and the result
  // appears with ack on the following cycle; data holds between acks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else if ((r_state == S_RESP) && !boot_en) begin
      r_ack  <= 1'b1;
      r_err  <= !r_in_range;
      r_data <= r_in_range ? r_mem[r_idx] : NOP;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end
  end

  // Boot-load write port; out-of-range writes are silently dropped.
  always_ff @(posedge clk) begin
    if (boot_en && boot_we && w_b_in_range) r_mem[w_b_idx] <= boot_wdata;
  end

endmodule

// File: tb/tb_riscv_imem_responder.sv
// Bench for riscv_imem_responder: four instances (WAIT_STATES 0..3) share one
// stimulus stream. A transaction-level model (pending fetch with a due cycle,
// plus a word array) predicts every instance; directed sequences and a
// vector table cover the corner cases with explicit constants.

module tb_riscv_imem_responder;

  localparam int          DEPTH = 16;
  localparam int          NI    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic                 clk;
  logic                 reset_n;
  logic                 imem_req;
  logic [31:0]          imem_address;
  logic                 boot_en;
  logic                 boot_we;
  logic [31:0]          boot_addr;
  logic [31:0]          boot_wdata;
  logic [NI-1:0][31:0]  d_data;
  logic [NI-1:0]        d_ack;
  logic [NI-1:0]        d_err;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    riscv_imem_responder #(
      .INST_ADDR_WIDTH(32),
      .INST_DATA_WIDTH(32),
      .MEM_DEPTH      (DEPTH),
      .WAIT_STATES    (g),
      .BASE_ADDR      (32'h0)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_address(imem_address),
      .imem_data_in(d_data[g]),
      .imem_ack    (d_ack[g]),
      .imem_err    (d_err[g]),
      .boot_en     (boot_en),
      .boot_we     (boot_we),
      .boot_addr   (boot_addr),
      .boot_wdata  (boot_wdata)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_pend  [NI];
  int          m_due   [NI];
  int          m_next  [NI];
  logic [31:0] m_pdata [NI];
  bit          m_perr  [NI];
  bit          e_ack   [NI];
  logic [31:0] e_data  [NI];
  bit          e_err   [NI];
  int          cyc = 0;

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(4 * DEPTH);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      cyc++;
      if (!reset_n) begin
        for (int k = 0; k < NI; k++) begin
          m_pend[k] = 0; m_next[k] = 0;
          e_ack[k] = 0; e_data[k] = '0; e_err[k] = 0;
        end
      end else begin
        for (int k = 0; k < NI; k++) begin
          e_ack[k] = 0;
          if (m_pend[k] && boot_en) begin
            m_pend[k] = 0; m_next[k] = 0;
          end
          if (m_pend[k] && m_due[k] == cyc) begin
            e_ack[k] = 1; e_data[k] = m_pdata[k]; e_err[k] = m_perr[k];
            m_pend[k] = 0;
          end
          if (imem_req && !boot_en && cyc >= m_next[k]) begin
            m_pend[k]  = 1;
            m_due[k]   = cyc + k + 1;
            m_next[k]  = m_due[k];
            m_perr[k]  = !in_rng(imem_address);
            m_pdata[k] = in_rng(imem_address) ? m_mem[imem_address >> 2] : NOP;
          end
        end
        if (boot_en && boot_we && in_rng(boot_addr)) m_mem[boot_addr >> 2] = boot_wdata;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < NI; k++) begin
          chk($sformatf("model ack ws%0d", k), 32'(d_ack[k]), 32'(e_ack[k]));
          if (e_ack[k] || !reset_n) begin
            chk($sformatf("model data ws%0d", k), d_data[k], e_data[k]);
            chk($sformatf("model err ws%0d", k), 32'(d_err[k]), 32'(e_err[k]));
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  // One fetch on instance k; addr changes to a2 and req drops after acceptance.
  task automatic fetch_ws(input int k, input logic [31:0] a, input logic [31:0] a2,
                          input logic [31:0] ed, input logic ee, input string nm);
    imem_req = 1'b1; imem_address = a;
    for (int c = 1; c <= k + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin imem_req = 1'b0; imem_address = a2; end
      chk({nm, " ack"}, 32'(d_ack[k]), 32'(c == k + 2));
      if (c == k + 2) begin
        chk({nm, " data"}, d_data[k], ed);
        chk({nm, " err"}, 32'(d_err[k]), 32'(ee));
      end
    end
  endtask

  task automatic drain(input int n);
    imem_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{32'h0,         32'h11,        1'b0};
    vt[1] = '{32'h4,         32'h22,        1'b0};
    vt[2] = '{32'h8,         32'h33,        1'b0};
    vt[3] = '{32'hC,         32'h44,        1'b0};
    vt[4] = '{32'h6,         32'h22,        1'b0};
    vt[5] = '{32'd63,        32'hA000_000F, 1'b0};
    vt[6] = '{32'd64,        NOP,           1'b1};
    vt[7] = '{32'hFFFF_FFFC, NOP,           1'b1};

    reset_n = 1'b0; imem_req = 1'b0; imem_address = '0;
    boot_en = 1'b0; boot_we = 1'b0; boot_addr = '0; boot_wdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset ack ws%0d", k), 32'(d_ack[k]), 32'd0);
      chk($sformatf("reset err ws%0d", k), 32'(d_err[k]), 32'd0);
      chk($sformatf("reset data ws%0d", k), d_data[k], 32'd0);
    end
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Boot-load the whole store with known contents.
    boot_en = 1'b1; boot_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      boot_addr  = 32'(i * 4);
      boot_wdata = (i < 4) ? 32'((i + 1) * 32'h11) : 32'hA000_0000 + 32'(i);
      @(negedge clk);
    end
    boot_en = 1'b0; boot_we = 1'b0;
    drain(2);

    // Back-to-back vector table on the zero-wait instance.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin imem_req = 1'b1; imem_address = vt[i].addr; end
      else imem_req = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("vec%0d ack", i - 1), 32'(d_ack[0]), 32'd1);
        chk($sformatf("vec%0d data", i - 1), d_data[0], vt[i-1].data);
        chk($sformatf("vec%0d err", i - 1), 32'(d_err[0]), 32'(vt[i-1].err));
      end
    end
    @(negedge clk);
    chk("vec tail ack", 32'(d_ack[0]), 32'd0);
    drain(6);

    // Three wait states; address moves to 8 while waiting.
    fetch_ws(3, 32'h4, 32'h8, 32'h22, 1'b0, "ws3 addr4");
    drain(6);

    // Out-of-range boot writes are dropped; write to word 5 then fetch at once.
    boot_en = 1'b1; boot_we = 1'b1; boot_addr = 32'd64; boot_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    boot_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    boot_addr = 32'd20; boot_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    boot_en = 1'b0; boot_we = 1'b0;
    fetch_ws(0, 32'd20, 32'd20, 32'hCAFE_F00D, 1'b0, "boot then fetch");
    drain(2);
    for (int i = 0; i < 4; i++) begin
      fetch_ws(0, 32'(i * 4), 32'(i * 4), 32'((i + 1) * 32'h11), 1'b0,
               $sformatf("readback w%0d", i));
      drain(1);
    end
    fetch_ws(0, 32'd64, 32'd0, NOP, 1'b1, "oob fetch");
    drain(6);

    // Abort: boot_en one cycle after acceptance with two wait states.
    imem_req = 1'b1; imem_address = 32'h0;
    @(negedge clk);
    imem_req = 1'b0; boot_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort no ack", 32'(d_ack[2]), 32'd0);
    end
    boot_en = 1'b0;
    @(negedge clk);
    fetch_ws(2, 32'h0, 32'h0, 32'h11, 1'b0, "after abort");
    drain(6);

    // Reset in the middle of WAIT.
    imem_req = 1'b1; imem_address = 32'h4;
    @(negedge clk);
    imem_req = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst mid ack", 32'(d_ack[2]), 32'd0);
    chk("rst mid err", 32'(d_err[2]), 32'd0);
    chk("rst mid data", d_data[2], 32'd0);
    chk("rst mid data ws0", d_data[0], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post rst no ack", 32'(d_ack[2]), 32'd0);
    end

    // Misaligned address held with req high: ws1 acks every other cycle,
    // ws0 every cycle.
    imem_req = 1'b1; imem_address = 32'h6;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("ws1 cadence c%0d", c), 32'(d_ack[1]), 32'(c >= 3 && (c % 2) == 1));
      if (c >= 3 && (c % 2) == 1) chk("ws1 misaligned data", d_data[1], 32'h22);
      chk($sformatf("ws0 cadence c%0d", c), 32'(d_ack[0]), 32'(c >= 2));
    end
    drain(6);

    // Randomised traffic checked by the model.
    for (int i = 0; i < 400; i++) begin
      boot_en      = ($urandom_range(0, 9) == 0);
      boot_we      = 1'($urandom_range(0, 1));
      boot_addr    = 32'($urandom_range(0, 4 * DEPTH + 12));
      boot_wdata   = $urandom;
      imem_req     = ($urandom_range(0, 3) != 0);
      imem_address = ($urandom_range(0, 15) == 0) ? $urandom
                                                  : 32'($urandom_range(0, 4 * DEPTH + 4));
      @(negedge clk);
    end
    boot_en = 1'b0; boot_we = 1'b0;
    drain(8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
